pe_rr_arbiter: RTL and testbench

//   Round-robin arbiter sharing one downstream priority-encoder datapath between
//   REQ_CNT requesters. Each requester sends bursts of WIDTH-bit words.
//   The arbiter grants one requester at a time and holds the grant for a whole

---
 rtl/pe_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 36 +++
 rtl/pe_rr_arbiter.sv | 113 +++++++++++
 tb/tb_pe_rr_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_arb_pkg.sv
// Shared types and helpers for the round-robin priority-encoder arbiter.
// Holds the FSM state encoding and a one-hot to binary index conversion.
package pe_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Callers zero-extend their vector to 64 bits and truncate the result.
    function automatic int unsigned onehot2idx(input logic [63:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (onehot[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: lowest requester above last_idx, else
// lowest requester overall. Uses lowest-set-bit isolation (x & -x).
module rr_pick
    import pe_arb_pkg::*;
#(
    parameter int REQ_CNT = 4,
    parameter int IDX_W   = $clog2(REQ_CNT)
) (
    input  logic [REQ_CNT-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [REQ_CNT-1:0] pick_onehot,
    output logic [IDX_W-1:0]   pick_idx
);

    localparam logic [REQ_CNT-1:0] ONE = {{(REQ_CNT-1){1'b0}}, 1'b1};

    logic [REQ_CNT-1:0] mask;
    logic [REQ_CNT-1:0] hi_req;
    logic [REQ_CNT-1:0] hi_iso;
    logic [REQ_CNT-1:0] all_iso;

    always_comb begin
        mask = '0;
        for (int i = 0; i < REQ_CNT; i++) begin
            mask[i] = (IDX_W'(i) > last_idx);
        end
    end

    assign hi_req  = req & mask;
    assign hi_iso  = hi_req & (~hi_req + ONE);
    assign all_iso = req & (~req + ONE);

    assign pick_onehot = (hi_req != '0) ? hi_iso : all_iso;
    assign pick_idx    = IDX_W'(onehot2idx(64'(pick_onehot)));

endmodule

// File: rtl/pe_rr_arbiter.sv
// Round-robin arbiter feeding one shared priority-encoder datapath.
// Grants are held for a whole burst, capped at MAX_BURST beats.
module pe_rr_arbiter
    import pe_arb_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int REQ_CNT   = 4,
    parameter int MAX_BURST = 16,
    localparam int IDX_W    = $clog2(REQ_CNT),
    localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                            clk_i,
    input  logic                            arst_n_i,
    input  logic [REQ_CNT-1:0][WIDTH-1:0]   req_data_i,
    input  logic [REQ_CNT-1:0]              req_val_i,
    input  logic [REQ_CNT-1:0]              req_last_i,
    output logic [REQ_CNT-1:0]              req_ready_o,
    output logic [WIDTH-1:0]                data_o,
    output logic                            data_val_o,
    output logic                            data_last_o,
    input  logic                            data_ready_i,
    output logic [REQ_CNT-1:0]              grant_o,
    output logic [IDX_W-1:0]                grant_idx_o
);

    arb_state_t         state_q, state_d;
    logic [REQ_CNT-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]   last_idx_q, last_idx_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [REQ_CNT-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               beat;

    rr_pick #(
        .REQ_CNT (REQ_CNT),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req         (req_val_i),
        .last_idx    (last_idx_q),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx)
    );

    // last_idx resets to the top index so requester 0 wins the first pick.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            last_idx_q  <= IDX_W'(REQ_CNT - 1);
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            last_idx_q  <= last_idx_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    always_comb begin
        data_o      = req_data_i[grant_idx_q];
        data_val_o  = 1'b0;
        data_last_o = 1'b0;
        req_ready_o = '0;
        if (state_q == GRANT) begin
            data_val_o               = req_val_i[grant_idx_q];
            data_last_o              = data_val_o &
                                       (req_last_i[grant_idx_q] |
                                        (beat_cnt_q == CNT_W'(MAX_BURST - 1)));
            req_ready_o[grant_idx_q] = data_ready_i;
        end
    end

    assign beat = data_val_o & data_ready_i;

    // A released grant always passes through IDLE, giving one bubble cycle.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        last_idx_d  = last_idx_q;
        beat_cnt_d  = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_val_i != '0) begin
                    grant_d     = pick_onehot;
                    grant_idx_d = pick_idx;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (beat) begin
                    if (data_last_o) begin
                        last_idx_d = grant_idx_q;
                        beat_cnt_d = '0;
                        grant_d    = '0;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = grant_idx_q;

endmodule

// File: tb/tb_pe_rr_arbiter.sv
// Directed bench for pe_rr_arbiter: reset, fairness, hold, burst cap,
// backpressure and reset in the middle of a grant.
module tb_pe_rr_arbiter;

    localparam int WIDTH     = 16;
    localparam int REQ_CNT   = 4;
    localparam int MAX_BURST = 16;

    logic                          clk_i;
    logic                          arst_n_i;
    logic [REQ_CNT-1:0][WIDTH-1:0] req_data_i;
    logic [REQ_CNT-1:0]            req_val_i;
    logic [REQ_CNT-1:0]            req_last_i;
    logic [REQ_CNT-1:0]            req_ready_o;
    logic [WIDTH-1:0]              data_o;
    logic                          data_val_o;
    logic                          data_last_o;
    logic                          data_ready_i;
    logic [REQ_CNT-1:0]            grant_o;
    logic [1:0]                    grant_idx_o;

    int tests_run;
    int tests_failed;
    int beats;

    pe_rr_arbiter #(
        .WIDTH     (WIDTH),
        .REQ_CNT   (REQ_CNT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk_i        (clk_i),
        .arst_n_i     (arst_n_i),
        .req_data_i   (req_data_i),
        .req_val_i    (req_val_i),
        .req_last_i   (req_last_i),
        .req_ready_o  (req_ready_o),
        .data_o       (data_o),
        .data_val_o   (data_val_o),
        .data_last_o  (data_last_o),
        .data_ready_i (data_ready_i),
        .grant_o      (grant_o),
        .grant_idx_o  (grant_idx_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Advance one clock; inputs are changed and outputs checked just after the edge.
    task automatic applyStimulus();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        arst_n_i     = 1'b0;
        req_data_i   = '0;
        req_val_i    = 4'b1111;
        req_last_i   = 4'b1111;
        data_ready_i = 1'b1;
        for (int i = 0; i < REQ_CNT; i++) req_data_i[i] = 16'hA000 + 16'(i);

        #3;
        checkOutput("rst_grant", 32'(grant_o), 32'h0);
        checkOutput("rst_idx", 32'(grant_idx_o), 32'h0);
        checkOutput("rst_val", 32'(data_val_o), 32'h0);
        checkOutput("rst_ready", 32'(req_ready_o), 32'h0);
        applyStimulus();
        applyStimulus();
        checkOutput("rst_hold_grant", 32'(grant_o), 32'h0);
        arst_n_i = 1'b1;

        applyStimulus();
        checkOutput("first_grant", 32'(grant_o), 32'b0001);
        checkOutput("first_idx", 32'(grant_idx_o), 32'h0);
        checkOutput("first_data", 32'(data_o), 32'hA000);
        checkOutput("first_last", 32'(data_last_o), 32'h1);

        for (int k = 1; k <= 4; k++) begin
            applyStimulus();
            checkOutput("fair_bubble_grant", 32'(grant_o), 32'h0);
            checkOutput("fair_bubble_val", 32'(data_val_o), 32'h0);
            checkOutput("fair_bubble_ready", 32'(req_ready_o), 32'h0);
            applyStimulus();
            checkOutput("fair_grant", 32'(grant_o), 32'(1 << (k % 4)));
            checkOutput("fair_idx", 32'(grant_idx_o), 32'(k % 4));
        end
        req_val_i = 4'b0001;
        applyStimulus();
        req_val_i  = 4'b0000;
        req_last_i = 4'b0000;

        // Cap: requester 1 streams 20 words with requester 3 also waiting.
        req_val_i = 4'b1010;
        applyStimulus();
        checkOutput("cap_grant1", 32'(grant_o), 32'b0010);
        for (int k = 0; k < 16; k++) begin
            req_data_i[1] = 16'h1000 + 16'(k);
            #1;
            checkOutput("cap_data", 32'(data_o), 32'(16'h1000 + 16'(k)));
            checkOutput("cap_last", 32'(data_last_o), 32'(k == 15));
            applyStimulus();
        end
        checkOutput("cap_bubble", 32'(grant_o), 32'h0);
        applyStimulus();
        checkOutput("cap_grant3", 32'(grant_o), 32'b1000);
        req_data_i[3] = 16'h3000;
        req_last_i    = 4'b1000;
        #1;
        checkOutput("cap_r3_data", 32'(data_o), 32'h3000);
        checkOutput("cap_r3_last", 32'(data_last_o), 32'h1);
        checkOutput("cap_r3_ready", 32'(req_ready_o), 32'b1000);
        applyStimulus();
        req_val_i  = 4'b0010;
        req_last_i = 4'b0000;
        checkOutput("cap_bubble2", 32'(grant_o), 32'h0);
        applyStimulus();
        checkOutput("cap_resume", 32'(grant_o), 32'b0010);
        for (int k = 16; k < 20; k++) begin
            req_data_i[1] = 16'h1000 + 16'(k);
            req_last_i[1] = (k == 19);
            #1;
            checkOutput("resume_data", 32'(data_o), 32'(16'h1000 + 16'(k)));
            checkOutput("resume_last", 32'(data_last_o), 32'(k == 19));
            applyStimulus();
        end
        req_val_i  = 4'b0000;
        req_last_i = 4'b0000;

        // Hold: requester 2 sends three words with a valid gap.
        req_val_i     = 4'b0100;
        req_data_i[2] = 16'h2001;
        applyStimulus();
        checkOutput("hold_idx", 32'(grant_idx_o), 32'h2);
        checkOutput("hold_data1", 32'(data_o), 32'h2001);
        checkOutput("hold_last1", 32'(data_last_o), 32'h0);
        checkOutput("hold_ready", 32'(req_ready_o), 32'b0100);
        applyStimulus();
        req_val_i = 4'b0000;
        #1;
        checkOutput("hold_gap_val", 32'(data_val_o), 32'h0);
        checkOutput("hold_gap_grant", 32'(grant_o), 32'b0100);
        applyStimulus();
        checkOutput("hold_gap_idx", 32'(grant_idx_o), 32'h2);
        req_val_i     = 4'b0100;
        req_data_i[2] = 16'h2002;
        #1;
        checkOutput("hold_data2", 32'(data_o), 32'h2002);
        checkOutput("hold_last2", 32'(data_last_o), 32'h0);
        applyStimulus();
        req_data_i[2] = 16'h2003;
        req_last_i    = 4'b0100;
        #1;
        checkOutput("hold_last3", 32'(data_last_o), 32'h1);
        applyStimulus();
        req_val_i  = 4'b0000;
        req_last_i = 4'b0000;
        checkOutput("hold_release", 32'(grant_o), 32'h0);

        // Backpressure: ready alternates, counter only advances on accepted beats.
        req_val_i = 4'b0001;
        applyStimulus();
        checkOutput("bp_grant", 32'(grant_o), 32'b0001);
        beats = 0;
        for (int c = 0; c < 31; c++) begin
            data_ready_i  = (c % 2 == 0);
            req_data_i[0] = 16'h0A00 + 16'(beats);
            #1;
            checkOutput("bp_data", 32'(data_o), 32'(16'h0A00 + 16'(beats)));
            checkOutput("bp_ready", 32'(req_ready_o), (c % 2 == 0) ? 32'h1 : 32'h0);
            checkOutput("bp_last", 32'(data_last_o), 32'(beats == 15));
            if (c % 2 == 0) beats++;
            applyStimulus();
        end
        data_ready_i = 1'b1;
        checkOutput("bp_release", 32'(grant_o), 32'h0);

        // Reset during a grant, with requester 1 also asking.
        applyStimulus();
        checkOutput("mid_grant", 32'(grant_o), 32'b0001);
        for (int b = 0; b < 2; b++) begin
            req_data_i[0] = 16'h0B00 + 16'(b);
            applyStimulus();
        end
        req_data_i[0] = 16'h0B02;
        req_val_i     = 4'b0011;
        #1;
        checkOutput("mid_val", 32'(data_val_o), 32'h1);
        arst_n_i = 1'b0;
        #1;
        checkOutput("mid_rst_grant", 32'(grant_o), 32'h0);
        checkOutput("mid_rst_val", 32'(data_val_o), 32'h0);
        checkOutput("mid_rst_ready", 32'(req_ready_o), 32'h0);
        applyStimulus();
        arst_n_i = 1'b1;
        #1;
        checkOutput("mid_post_rst", 32'(grant_o), 32'h0);
        applyStimulus();
        checkOutput("mid_regrant", 32'(grant_o), 32'b0001);
        checkOutput("mid_regrant_data", 32'(data_o), 32'h0B02);

        req_val_i = 4'b0000;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
